laser_array_ctrl: RTL and testbench

Parametrised controller for a bank of laser towers sharing one VGA laser draw/erase datapath. Each tower slot runs its own laser FSM driven by placement, car-in-range and the frame draw tick. A round-robin arbiter serialises the slots' draw/erase requests onto the single shared datapath. Per-slot cooldown counters time the re-arm delay internally, and a per-slot hit pulse is raised when a laser lands. It sits between the tower placement/collision logic and the shared laser drawing datapath.

---
 rtl/laser_array_ctrl_if.sv | 10 +
 rtl/laser_array_ctrl.sv | 136 +++++++++++++
 tb/tb_laser_array_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/laser_array_ctrl_if.sv
// laser_array_ctrl_if: handshake between the tower controller and the shared laser draw/erase datapath
interface laser_array_ctrl_if #(parameter int SEL_W = 2) ();
  logic op_start;
  logic op_erase;
  logic [SEL_W-1:0] op_sel;
  logic busy;
  logic op_done;
  modport master (output op_start, op_erase, op_sel, busy, input op_done);
  modport slave (input op_start, op_erase, op_sel, busy, output op_done);
endinterface

// File: rtl/laser_array_ctrl.sv
// laser_array_ctrl: per-slot laser FSMs with cooldown, round-robin arbitrated onto one shared
// draw/erase datapath
module laser_array_ctrl #(
  parameter int N_TOWERS = 4,
  parameter int SEL_W = 2,
  parameter int CD_W = 26,
  parameter int COOLDOWN = 50000000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_TOWERS-1:0] tower_placed,
  input  logic [N_TOWERS-1:0] car_in_range,
  input  logic                enable_draw,
  laser_array_ctrl_if.master  op,
  output logic [N_TOWERS-1:0] drawn,
  output logic [N_TOWERS-1:0] fire
);
  typedef enum logic [2:0] {
    S_DISABLED, S_WAIT, S_REQ_DRAW, S_DRAWING, S_REQ_ERASE, S_ERASING, S_COOLDOWN
  } slot_e;
  typedef enum logic [0:0] {A_IDLE, A_BUSY} arb_e;
  slot_e st_q [N_TOWERS];
  slot_e st_d [N_TOWERS];
  logic [CD_W-1:0] cnt_q [N_TOWERS];
  logic [CD_W-1:0] cnt_d [N_TOWERS];
  logic [N_TOWERS-1:0] rem_q, rem_d, drawn_q, drawn_d, fire_q, fire_d, req;
  arb_e arb_q, arb_d;
  logic [SEL_W-1:0] rr_q, rr_d, sel_q, sel_d, gnt_idx;
  logic start_q, start_d, erase_q, erase_d, gnt_v, done;
  assign done = arb_q == A_BUSY && op.op_done && !start_q;
  always_comb begin
    for (int i = 0; i < N_TOWERS; i++)
      req[i] = st_q[i] == S_REQ_ERASE || (st_q[i] == S_REQ_DRAW && tower_placed[i]);
  end
  // descending scan so the lowest offset from rr_q wins
  always_comb begin
    gnt_v = 1'b0;
    gnt_idx = '0;
    for (int k = N_TOWERS - 1; k >= 0; k--) begin
      if (arb_q == A_IDLE && req[(int'(rr_q) + k) % N_TOWERS]) begin
        gnt_v = 1'b1;
        gnt_idx = SEL_W'((int'(rr_q) + k) % N_TOWERS);
      end
    end
  end
  always_comb begin
    arb_d = arb_q;
    rr_d = rr_q;
    start_d = 1'b0;
    erase_d = erase_q;
    sel_d = sel_q;
    if (gnt_v) begin
      arb_d = A_BUSY;
      start_d = 1'b1;
      sel_d = gnt_idx;
      erase_d = st_q[gnt_idx] == S_REQ_ERASE;
      rr_d = gnt_idx == SEL_W'(N_TOWERS - 1) ? '0 : gnt_idx + 1'b1;
    end else if (done) arb_d = A_IDLE;
  end
  always_comb begin
    for (int i = 0; i < N_TOWERS; i++) begin
      st_d[i] = st_q[i];
      cnt_d[i] = cnt_q[i];
      rem_d[i] = rem_q[i];
      drawn_d[i] = drawn_q[i];
      fire_d[i] = 1'b0;
      case (st_q[i])
        S_DISABLED: st_d[i] = tower_placed[i] ? S_WAIT : S_DISABLED;
        S_WAIT: begin
          if (!tower_placed[i]) begin
            st_d[i] = drawn_q[i] ? S_REQ_ERASE : S_DISABLED;
            rem_d[i] = drawn_q[i];
          end else if (enable_draw && car_in_range[i] && !drawn_q[i]) st_d[i] = S_REQ_DRAW;
          else if (enable_draw && !car_in_range[i] && drawn_q[i]) st_d[i] = S_REQ_ERASE;
        end
        S_REQ_DRAW: st_d[i] = !tower_placed[i] ? S_DISABLED : (gnt_v && gnt_idx == SEL_W'(i)) ? S_DRAWING : S_REQ_DRAW;
        S_REQ_ERASE: st_d[i] = (gnt_v && gnt_idx == SEL_W'(i)) ? S_ERASING : S_REQ_ERASE;
        S_DRAWING: begin
          if (done && sel_q == SEL_W'(i)) begin
            st_d[i] = S_WAIT;
            drawn_d[i] = 1'b1;
            fire_d[i] = 1'b1;
          end
        end
        S_ERASING: begin
          if (done && sel_q == SEL_W'(i)) begin
            drawn_d[i] = 1'b0;
            rem_d[i] = 1'b0;
            st_d[i] = rem_q[i] ? S_DISABLED : S_COOLDOWN;
            cnt_d[i] = rem_q[i] ? '0 : CD_W'(COOLDOWN - 1);
          end
        end
        S_COOLDOWN: begin
          st_d[i] = !tower_placed[i] ? S_DISABLED : cnt_q[i] == '0 ? S_WAIT : S_COOLDOWN;
          cnt_d[i] = (!tower_placed[i] || cnt_q[i] == '0) ? '0 : cnt_q[i] - 1'b1;
        end
        default: st_d[i] = S_DISABLED;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arb_q <= A_IDLE;
      rr_q <= '0;
      start_q <= 1'b0;
      erase_q <= 1'b0;
      sel_q <= '0;
      rem_q <= '0;
      drawn_q <= '0;
      fire_q <= '0;
      for (int i = 0; i < N_TOWERS; i++) begin
        st_q[i] <= S_DISABLED;
        cnt_q[i] <= '0;
      end
    end else begin
      arb_q <= arb_d;
      rr_q <= rr_d;
      start_q <= start_d;
      erase_q <= erase_d;
      sel_q <= sel_d;
      rem_q <= rem_d;
      drawn_q <= drawn_d;
      fire_q <= fire_d;
      for (int i = 0; i < N_TOWERS; i++) begin
        st_q[i] <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
  assign op.op_start = start_q;
  assign op.op_erase = erase_q;
  assign op.op_sel = sel_q;
  assign op.busy = arb_q == A_BUSY;
  assign drawn = drawn_q;
  assign fire = fire_q;
endmodule

// File: tb/tb_laser_array_ctrl.sv
// tb_laser_array_ctrl: directed scenarios for laser_array_ctrl with N_TOWERS=4, COOLDOWN=8;
// inputs change and outputs are sampled on the falling edge
module tb_laser_array_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable_draw = 1'b0;
  logic [3:0] tower_placed = '0;
  logic [3:0] car_in_range = '0;
  logic [3:0] drawn, fire;
  int errors = 0;
  int checks = 0;
  laser_array_ctrl_if #(.SEL_W(2)) bus ();
  laser_array_ctrl #(.N_TOWERS(4), .SEL_W(2), .CD_W(26), .COOLDOWN(8)) dut (
    .clk(clk), .resetn(resetn), .tower_placed(tower_placed), .car_in_range(car_in_range),
    .enable_draw(enable_draw), .op(bus), .drawn(drawn), .fire(fire));
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_draw();
    enable_draw = 1'b1;
    tick();
    enable_draw = 1'b0;
  endtask
  task automatic pulse_done();
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    tower_placed = '0;
    car_in_range = '0;
    tick(2);
    resetn = 1'b1;
    tick();
  endtask
  task automatic test_op(input logic [1:0] s, input logic e);
    int n = 0;
    while (!bus.op_start && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (bus.op_start !== 1'b1) begin
      errors++;
      $display("FAIL op_timeout slot %0d: op_start=%b required 1", s, bus.op_start);
    end
    checks++;
    if ({bus.op_sel, bus.op_erase, bus.busy} !== {s, e, 1'b1}) begin
      errors++;
      $display("FAIL op_issue: sel/erase/busy=%b required %b", {bus.op_sel, bus.op_erase, bus.busy}, {s, e, 1'b1});
    end
    tick();
    checks++;
    if ({bus.op_start, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL op_hold slot %0d: start/busy=%b required 01", s, {bus.op_start, bus.busy});
    end
    tick();
    pulse_done();
    checks++;
    if ({bus.op_start, bus.busy, drawn[s], fire} !== {2'b00, !e, e ? 4'b0 : 4'b1 << s}) begin
      errors++;
      $display("FAIL op_complete slot %0d: start/busy/drawn/fire=%b required %b", s,
               {bus.op_start, bus.busy, drawn[s], fire}, {2'b00, !e, e ? 4'b0 : 4'b1 << s});
    end
  endtask
  task automatic test_reset();
    tick(2);
    checks++;
    if ({bus.op_start, bus.op_erase, bus.op_sel, bus.busy, drawn, fire} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {bus.op_start, bus.op_erase, bus.op_sel, bus.busy, drawn, fire});
    end
  endtask
  task automatic test_draw();
    resetn = 1'b1;
    tower_placed = 4'b0001;
    car_in_range = 4'b0001;
    tick();
    pulse_draw();
    checks++;
    if (bus.op_start !== 1'b0) begin
      errors++;
      $display("FAIL draw_early: op_start=%b required 0", bus.op_start);
    end
    tick();
    checks++;
    if ({bus.op_start, bus.op_erase, bus.op_sel, bus.busy} !== 5'b10001) begin
      errors++;
      $display("FAIL draw_start: start/erase/sel/busy=%b required 10001", {bus.op_start, bus.op_erase, bus.op_sel, bus.busy});
    end
    tick();
    checks++;
    if ({bus.op_start, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL draw_pulse: start/busy=%b required 01", {bus.op_start, bus.busy});
    end
    pulse_done();
    checks++;
    if ({fire, drawn, bus.busy} !== 9'b0001_0001_0) begin
      errors++;
      $display("FAIL draw_done: fire/drawn/busy=%b required 000100010", {fire, drawn, bus.busy});
    end
    tick();
    checks++;
    if (fire !== 4'b0) begin
      errors++;
      $display("FAIL fire_width: fire=%b required 0000", fire);
    end
  endtask
  task automatic test_cooldown();
    logic seen = 1'b0;
    car_in_range = 4'b0000;
    pulse_draw();
    tick();
    checks++;
    if ({bus.op_start, bus.op_erase, bus.op_sel} !== 4'b1100) begin
      errors++;
      $display("FAIL erase_start: start/erase/sel=%b required 1100", {bus.op_start, bus.op_erase, bus.op_sel});
    end
    tick();
    pulse_done();
    checks++;
    if ({drawn, fire} !== 8'b0) begin
      errors++;
      $display("FAIL erase_done: drawn/fire=%b required 0", {drawn, fire});
    end
    car_in_range = 4'b0001;
    pulse_draw();
    repeat (6) begin
      seen |= bus.op_start;
      tick();
    end
    pulse_draw();
    repeat (4) begin
      seen |= bus.op_start;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL cooldown_ignore: op_start seen=%b required 0", seen);
    end
    pulse_draw();
    tick();
    checks++;
    if ({bus.op_start, bus.op_erase, bus.op_sel} !== 4'b1000) begin
      errors++;
      $display("FAIL cooldown_rearm: start/erase/sel=%b required 1000", {bus.op_start, bus.op_erase, bus.op_sel});
    end
    tick();
    pulse_done();
    checks++;
    if (drawn !== 4'b0001) begin
      errors++;
      $display("FAIL rearm_drawn: drawn=%b required 0001", drawn);
    end
  endtask
  task automatic test_round_robin();
    do_reset();
    tower_placed = 4'hF;
    car_in_range = 4'hF;
    tick();
    pulse_draw();
    test_op(2'd0, 1'b0);
    test_op(2'd1, 1'b0);
    test_op(2'd2, 1'b0);
    test_op(2'd3, 1'b0);
    car_in_range = 4'b1100;
    pulse_draw();
    test_op(2'd0, 1'b1);
    test_op(2'd1, 1'b1);
    tick(12);
    car_in_range = 4'b0011;
    pulse_draw();
    test_op(2'd2, 1'b1);
    test_op(2'd3, 1'b1);
    test_op(2'd0, 1'b0);
    test_op(2'd1, 1'b0);
    checks++;
    if (drawn !== 4'b0011) begin
      errors++;
      $display("FAIL rr_drawn: drawn=%b required 0011", drawn);
    end
  endtask
  task automatic test_removal();
    logic seen = 1'b0;
    do_reset();
    tower_placed = 4'b0111;
    car_in_range = 4'b0100;
    tick();
    pulse_draw();
    test_op(2'd2, 1'b0);
    car_in_range = 4'b0101;
    pulse_draw();
    tick();
    checks++;
    if ({bus.op_start, bus.op_sel} !== 3'b100) begin
      errors++;
      $display("FAIL wrap_grant: start/sel=%b required 100", {bus.op_start, bus.op_sel});
    end
    car_in_range = 4'b0111;
    pulse_draw();
    tower_placed = 4'b0101;
    tick();
    pulse_done();
    repeat (6) begin
      seen |= bus.op_start;
      tick();
    end
    checks++;
    if ({seen, drawn} !== 5'b0_0101) begin
      errors++;
      $display("FAIL cancel_req: seen/drawn=%b required 00101", {seen, drawn});
    end
    tower_placed = 4'b0001;
    test_op(2'd2, 1'b1);
    tower_placed = 4'b0101;
    tick();
    pulse_draw();
    tick();
    checks++;
    if ({bus.op_start, bus.op_erase, bus.op_sel} !== 4'b1010) begin
      errors++;
      $display("FAIL removal_no_cooldown: start/erase/sel=%b required 1010", {bus.op_start, bus.op_erase, bus.op_sel});
    end
    tick();
    pulse_done();
  endtask
  task automatic test_reset_mid();
    logic seen = 1'b0;
    do_reset();
    tower_placed = 4'b1001;
    car_in_range = 4'b1001;
    tick();
    pulse_draw();
    test_op(2'd0, 1'b0);
    tick();
    checks++;
    if ({bus.op_start, bus.op_sel} !== 3'b111) begin
      errors++;
      $display("FAIL second_grant: start/sel=%b required 111", {bus.op_start, bus.op_sel});
    end
    tick();
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.op_start, bus.op_erase, bus.op_sel, bus.busy, drawn, fire} !== 13'b0) begin
      errors++;
      $display("FAIL async_reset: got %b required 0", {bus.op_start, bus.op_erase, bus.op_sel, bus.busy, drawn, fire});
    end
    tick();
    resetn = 1'b1;
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
    repeat (3) begin
      seen |= bus.op_start | bus.busy | (|fire) | (|drawn);
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL late_done: activity=%b required 0", seen);
    end
    pulse_draw();
    test_op(2'd0, 1'b0);
  endtask
  initial begin
    bus.op_done = 1'b0;
    test_reset();
    test_draw();
    test_cooldown();
    test_round_robin();
    test_removal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
